// File: rtl/ram_seq_pkg.sv
// ============================================================================
// Module      : ram_seq_pkg
// Description : Shared types, constants and helpers for the RAM sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_seq_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int FIFO_DEPTH = 3;
    localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PW    = $clog2(FIFO_DEPTH);

    // Number of bits needed to hold the value 'depth' (0 for 0).
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (d > 0) begin
                r = r + 1;
                d = d >> 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_seq_rsp_fifo.sv
// ============================================================================
// Module      : ram_seq_rsp_fifo
// Description : Small synchronous response FIFO with valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_seq_rsp_fifo
    import ram_seq_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [FIFO_CW-1:0] count
);

    logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_PW-1:0] r_rd_ptr;
    logic [FIFO_PW-1:0] r_wr_ptr;
    logic [FIFO_CW-1:0] r_count;
    logic               w_pop;
    logic               w_push;

    function automatic logic [FIFO_PW-1:0] next_ptr(input logic [FIFO_PW-1:0] p);
        return (p == FIFO_PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = (r_count != '0) && out_ready;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_push = push && ((r_count != FIFO_CW'(FIFO_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/single_port_ram_sequencer.sv
// ============================================================================
// Module      : single_port_ram_sequencer
// Description : Command/response front end for a single-port write-first RAM
//               with optional zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module single_port_ram_sequencer
    import ram_seq_pkg::*;
#(
    parameter int  RAM_WIDTH      = 32,
    parameter int  RAM_DEPTH      = 1024,
    parameter bit  CLEAR_ON_RESET = 1'b1,
    parameter bit  WRITE_RSP      = 1'b1,
    localparam int AW             = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [AW-1:0]        cmd_addr,
    input  logic [RAM_WIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RAM_WIDTH-1:0] rsp_data,
    output logic                 rsp_we,
    input  logic                 clr_start,
    output logic                 busy,
    output logic [AW-1:0]        ram_addr,
    output logic [RAM_WIDTH-1:0] ram_din,
    output logic                 ram_ena_n,
    output logic                 ram_wea_n,
    input  logic [RAM_WIDTH-1:0] ram_dout
);

    state_t               r_state;
    logic [AW-1:0]        r_clr_addr;
    logic                 r_inflight;
    logic                 r_tag;
    logic                 w_accept;
    logic                 w_credit;
    logic                 w_responds;
    logic                 w_clr_go;
    logic                 w_fifo_valid;
    logic [RAM_WIDTH:0]   w_fifo_out;
    logic [FIFO_CW-1:0]   w_fifo_count;

    // Credit counts both queued and in-flight responses so the FIFO never overflows.
    assign w_credit   = (int'(w_fifo_count) + int'(r_inflight)) < FIFO_DEPTH;
    assign cmd_ready  = !rsta && (r_state == ST_RUN) && w_credit;
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_responds = w_accept && (!cmd_we || WRITE_RSP);
    assign w_clr_go   = (r_state == ST_RUN) && clr_start && (w_fifo_count == '0)
                        && !r_inflight && !w_accept;

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_addr <= '0;
            r_inflight <= 1'b0;
            r_tag      <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_inflight <= 1'b0;
                    if (r_clr_addr == AW'(RAM_DEPTH - 1)) begin
                        r_state    <= ST_RUN;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: begin
                    r_inflight <= w_responds;
                    r_tag      <= cmd_we;
                    if (w_clr_go) begin
                        r_state    <= ST_CLEAR;
                        r_clr_addr <= '0;
                    end
                end
            endcase
        end
    end

    // The RAM output register holds the read data (or the written data, being
    // write-first) one cycle after the access.
    ram_seq_rsp_fifo #(
        .WIDTH     (RAM_WIDTH + 1)
    ) u_rsp_fifo (
        .clk       (clka),
        .rst       (rsta),
        .push      (r_inflight),
        .push_data ({r_tag, ram_dout}),
        .out_valid (w_fifo_valid),
        .out_ready (rsp_ready),
        .out_data  (w_fifo_out),
        .count     (w_fifo_count)
    );

    assign rsp_valid = w_fifo_valid && !rsta;
    assign rsp_data  = w_fifo_out[RAM_WIDTH-1:0];
    assign rsp_we    = w_fifo_out[RAM_WIDTH];
    assign busy      = !rsta && (r_state == ST_CLEAR);

    always_comb begin
        ram_ena_n = 1'b1;
        ram_wea_n = 1'b1;
        ram_addr  = '0;
        ram_din   = '0;
        if (!rsta) begin
            if (r_state == ST_CLEAR) begin
                ram_ena_n = 1'b0;
                ram_wea_n = 1'b0;
                ram_addr  = r_clr_addr;
            end else begin
                ram_ena_n = !w_accept;
                ram_wea_n = !cmd_we;
                ram_addr  = cmd_addr;
                ram_din   = cmd_wdata;
            end
        end
    end

endmodule

`default_nettype wire
